// File: rtl/ram_pkg.sv
// Shared definitions for the single-port parity RAM and its access master:
// default widths and the access FSM state encoding.
package ram_pkg;

    localparam int unsigned MEM_WIDTH = 16;
    localparam int unsigned ADDR_SIZE = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_EXEC,
        ST_DOUT,
        ST_CAPT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/ram_access_master_if.sv
// Request/response handshake bundle between a command front end (master)
// and the RAM access master (slave).
interface ram_access_master_if #(
    parameter int MEM_WIDTH = ram_pkg::MEM_WIDTH,
    parameter int ADDR_SIZE = ram_pkg::ADDR_SIZE
);

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [MEM_WIDTH-1:0] req_data;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_write;
    logic [MEM_WIDTH-1:0] rsp_data;
    logic                 rsp_parity;
    logic                 rsp_perr;

    modport master (
        output req_valid, req_write, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_write, rsp_data, rsp_parity, rsp_perr
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_write, rsp_data, rsp_parity, rsp_perr
    );

endinterface

// File: rtl/ram_parity_chk.sv
// Odd-parity checker: expected parity is the XNOR-reduction of the data,
// mismatch flags a parity bit that disagrees with it.
module ram_parity_chk #(
    parameter int MEM_WIDTH = ram_pkg::MEM_WIDTH
) (
    input  logic [MEM_WIDTH-1:0] data_i,
    input  logic                 parity_i,
    output logic                 exp_parity_o,
    output logic                 mismatch_o
);

    always_comb begin
        exp_parity_o = ~^data_i;
        mismatch_o   = parity_i ^ exp_parity_o;
    end

endmodule

// File: rtl/ram_access_master.sv
// Initiator for the single-port parity RAM: accepts word requests, sequences
// the RAM strobes for the configured pipeline depth, returns one response each.
module ram_access_master
    import ram_pkg::*;
#(
    parameter int MEM_WIDTH     = ram_pkg::MEM_WIDTH,
    parameter int ADDR_SIZE     = ram_pkg::ADDR_SIZE,
    parameter int ADDR_PIPELINE = 0,
    parameter int DOUT_PIPELINE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_access_master_if.slave   bus,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0] ram_din,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_blk_select,
    output logic                 ram_addr_en,
    output logic                 ram_dout_en,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    input  logic                 ram_parity
);

    state_e               state_q, state_d;
    logic                 write_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [MEM_WIDTH-1:0] din_q;
    logic                 rsp_write_q;
    logic [MEM_WIDTH-1:0] rsp_data_q;
    logic                 rsp_parity_q;
    logic                 rsp_perr_q;
    logic                 perr_calc;
    logic                 exp_parity_unused;

    ram_parity_chk #(
        .MEM_WIDTH (MEM_WIDTH)
    ) u_parity_chk (
        .data_i       (ram_dout),
        .parity_i     (ram_parity),
        .exp_parity_o (exp_parity_unused),
        .mismatch_o   (perr_calc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.req_valid) state_d = (ADDR_PIPELINE != 0) ? ST_ADDR : ST_EXEC;
            ST_ADDR: state_d = ST_EXEC;
            ST_EXEC: begin
                if (write_q)                 state_d = ST_RESP;
                else if (DOUT_PIPELINE != 0) state_d = ST_DOUT;
                else                         state_d = ST_CAPT;
            end
            ST_DOUT: state_d = ST_CAPT;
            ST_CAPT: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Write responses carry no data, so their rsp fields are zeroed at accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            rsp_write_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_parity_q <= 1'b0;
            rsp_perr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.req_valid) begin
                write_q     <= bus.req_write;
                addr_q      <= bus.req_addr;
                din_q       <= bus.req_data;
                rsp_write_q <= bus.req_write;
                if (bus.req_write) begin
                    rsp_data_q   <= '0;
                    rsp_parity_q <= 1'b0;
                    rsp_perr_q   <= 1'b0;
                end
            end
            if (state_q == ST_CAPT) begin
                rsp_data_q   <= ram_dout;
                rsp_parity_q <= ram_parity;
                rsp_perr_q   <= perr_calc;
            end
        end
    end

    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.rsp_valid  = (state_q == ST_RESP);
        bus.rsp_write  = rsp_write_q;
        bus.rsp_data   = rsp_data_q;
        bus.rsp_parity = rsp_parity_q;
        bus.rsp_perr   = rsp_perr_q;
        ram_addr       = addr_q;
        ram_din        = din_q;
        ram_addr_en    = (state_q == ST_ADDR);
        ram_blk_select = (state_q == ST_EXEC);
        ram_wr_en      = (state_q == ST_EXEC) && write_q;
        ram_rd_en      = (state_q == ST_EXEC) && !write_q;
        ram_dout_en    = (state_q == ST_DOUT);
    end

endmodule
